// File: rtl/cpu_instr_feeder.sv
// Instruction feeder: a small FIFO of 16-bit instructions and an issue FSM that
// hands them one at a time to the cpu over its load/s/w handshake. It counts
// completions and keeps sticky overflow and watchdog-timeout flags.
module cpu_instr_feeder #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    input  logic          run,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [15:0]   cpu_in,
    output logic          cpu_load,
    output logic          cpu_s,
    input  logic          cpu_w,
    output logic          busy,
    output logic [7:0]    issued,
    output logic          overflow,
    output logic          timeout_err
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} state_e;

    state_e          state_q, state_d;
    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q, count_d;
    logic            full_q, empty_q;
    logic [15:0]     cpu_in_q, cpu_in_d;
    logic [7:0]      issued_q, issued_d;
    logic            ovf_q, ovf_d;
    logic            tmo_q, tmo_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            pop, push, wd_hit;

    // Issue FSM next state, pop decision, watchdog and completion counting.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        cpu_in_d = cpu_in_q;
        issued_d = issued_q;
        tmo_d    = tmo_q;
        wd_d     = wd_q;
        // Last allowed cycle in START/WAIT_DONE: the watchdog has already seen TIMEOUT-1.
        wd_hit   = (wd_q == WW'(TIMEOUT - 1));
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (run && !empty_q && !tmo_q) begin
                    state_d = LOAD;
                    pop     = 1'b1;
                end
            end
            LOAD: begin
                wd_d    = '0;
                state_d = START;
            end
            START: begin
                wd_d = wd_q + 1'b1;
                if (!cpu_w) begin
                    state_d = WAIT_DONE;
                end else if (wd_hit) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                wd_d = wd_q + 1'b1;
                // A completion seen on the last watchdog cycle still counts.
                if (cpu_w) begin
                    issued_d = issued_q + 8'd1;
                    if (run && !empty_q) begin
                        state_d = LOAD;
                        pop     = 1'b1;
                        wd_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wd_hit) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) cpu_in_d = mem_q[rptr_q];
    end

    // FIFO bookkeeping: a push into a full FIFO is allowed only when a pop frees a slot.
    always_comb begin
        push    = wr_en && (!full_q || pop);
        ovf_d   = ovf_q || (wr_en && full_q && !pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // State, pointers, counters and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            cpu_in_q <= '0;
            issued_q <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q  <= count_d;
            full_q   <= (count_d == (AW+1)'(DEPTH));
            empty_q  <= (count_d == '0);
            cpu_in_q <= cpu_in_d;
            issued_q <= issued_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
            wd_q     <= wd_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign cpu_in      = cpu_in_q;
    assign cpu_load    = (state_q == LOAD);
    assign cpu_s       = (state_q == START);
    assign busy        = (state_q != IDLE);
    assign issued      = issued_q;
    assign overflow    = ovf_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_cpu_instr_feeder.sv
// Directed bench for cpu_instr_feeder with a behavioural cpu handshake model.
module tb_cpu_instr_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        run = 1'b0;
    logic        full, empty, cpu_load, cpu_s, busy, overflow, timeout_err;
    logic [3:0]  count;
    logic [15:0] cpu_in;
    logic [7:0]  issued;
    logic        cpu_w = 1'b1;
    logic        hang = 1'b0;

    int vecs = 0;
    int errs = 0;
    int loads = 0;
    int scyc = 0;
    int ph = 0;
    logic [15:0] ldlog[$];

    cpu_instr_feeder #(.DEPTH(8), .AW(3), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .run(run),
        .full(full), .empty(empty), .count(count), .cpu_in(cpu_in),
        .cpu_load(cpu_load), .cpu_s(cpu_s), .cpu_w(cpu_w), .busy(busy),
        .issued(issued), .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // cpu model: w drops one cycle after s is seen, stays low 3 cycles, then rises.
    always @(negedge clk) begin
        if (!reset || hang) begin
            cpu_w = 1'b1;
            ph    = 0;
        end else begin
            case (ph)
                0: if (cpu_s) ph = 1;
                1: begin cpu_w = 1'b0; ph = 2; end
                2, 3: ph = ph + 1;
                default: begin cpu_w = 1'b1; ph = 0; end
            endcase
        end
    end

    // Monitor: log every issued word and count cycles with s high.
    always @(negedge clk) begin
        if (reset) begin
            if (cpu_load) begin
                loads = loads + 1;
                ldlog.push_back(cpu_in);
            end
            if (cpu_s) scyc = scyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        run   = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_issued(input string tag, input logic [7:0] n);
        int k;
        k = 0;
        while (!(issued == n && !busy) && k < 400) begin
            tick();
            k++;
        end
        chk(tag, (k < 400), 1);
    endtask

    int lb, sb, k;

    initial begin
        // 1: reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_s", cpu_s, 0);
        chk("rst_load", cpu_load, 0);
        chk("rst_in", cpu_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {full, overflow, timeout_err}, 0);
        chk("rst_issued", issued, 0);
        reset = 1'b1;
        tick();

        // 2: single issue and latency
        lb = loads; sb = scyc;
        push(16'hD004);
        chk("s_count", count, 1);
        chk("s_empty", empty, 0);
        run = 1'b1;
        tick();
        chk("s_load", cpu_load, 1);
        chk("s_in", cpu_in, 16'hD004);
        chk("s_popped", count, 0);
        tick();
        chk("s_load_off", cpu_load, 0);
        chk("s_s_on", cpu_s, 1);
        wait_issued("s_done", 8'd1);
        chk("s_issued", issued, 1);
        chk("s_empty2", empty, 1);
        chk("s_nload", loads - lb, 1);
        chk("s_scyc", scyc - sb, 2);
        run = 1'b0;

        // 3: stream of four in FIFO order
        do_reset();
        lb = loads;
        push(16'hD004); push(16'hC020); push(16'hA269); push(16'hB390);
        chk("st_count4", count, 4);
        run = 1'b1;
        wait_issued("st_done", 8'd4);
        chk("st_nload", loads - lb, 4);
        chk("st_w0", ldlog[lb],   16'hD004);
        chk("st_w1", ldlog[lb+1], 16'hC020);
        chk("st_w2", ldlog[lb+2], 16'hA269);
        chk("st_w3", ldlog[lb+3], 16'hB390);
        chk("st_count0", count, 0);

        // 4: fill, overflow, ninth word dropped
        do_reset();
        lb = loads;
        for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i));
        chk("f_full", full, 1);
        chk("f_count8", count, 8);
        chk("f_novf", overflow, 0);
        push(16'h1008);
        chk("f_ovf", overflow, 1);
        chk("f_count_hold", count, 8);
        run = 1'b1;
        wait_issued("f_done", 8'd8);
        chk("f_nload", loads - lb, 8);
        chk("f_last", ldlog[lb+7], 16'h1007);
        chk("f_empty", empty, 1);

        // 5: push accepted while full because WAIT_DONE->LOAD pops
        do_reset();
        lb = loads;
        for (int i = 0; i < 8; i++) push(16'h2000 + 16'(i));
        run = 1'b1;
        tick();
        chk("fp_pop1", count, 7);
        push(16'h2008);
        chk("fp_full", full, 1);
        chk("fp_count8", count, 8);
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            #1;
            if (busy && !cpu_s && !cpu_load && cpu_w) break;
            k++;
        end
        chk("fp_found_wd", (k < 50), 1);
        wr_en = 1'b1; wr_data = 16'h2AAA;
        tick();
        wr_en = 1'b0;
        chk("fp_count_keep", count, 8);
        chk("fp_full_keep", full, 1);
        chk("fp_novf", overflow, 0);
        chk("fp_next", cpu_in, 16'h2001);
        wait_issued("fp_done", 8'd10);
        chk("fp_nload", loads - lb, 10);
        chk("fp_w8", ldlog[lb+8], 16'h2008);
        chk("fp_w9", ldlog[lb+9], 16'h2AAA);

        // 6: timeout with a hung cpu
        do_reset();
        hang = 1'b1;
        lb = loads; sb = scyc;
        push(16'hD004);
        run = 1'b1;
        k = 0;
        while (!timeout_err && k < 200) begin
            tick();
            k++;
        end
        chk("t_seen", timeout_err, 1);
        chk("t_scyc", scyc - sb, 64);
        chk("t_s_off", cpu_s, 0);
        chk("t_idle", busy, 0);
        push(16'hC020); push(16'hA269);
        repeat (20) tick();
        chk("t_no_issue", loads - lb, 1);
        chk("t_count", count, 2);
        chk("t_issued", issued, 0);
        chk("t_sticky", timeout_err, 1);

        // Asynchronous reset in the middle of an issue
        do_reset();
        hang = 1'b0;
        push(16'hD004); push(16'hC020);
        run = 1'b1;
        tick(); tick();
        chk("mr_s_on", cpu_s, 1);
        reset = 1'b0;
        #1;
        chk("mr_s_off", cpu_s, 0);
        chk("mr_busy", busy, 0);
        chk("mr_count", count, 0);
        chk("mr_empty", empty, 1);
        @(negedge clk);
        run = 1'b0;
        reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
